// File: rtl/dispatch_arbiter_pkg.sv
// Shared dispatch parameters: default widths, requester-count limits and the
// round-robin pointer helper used by the arbiter top.
package dispatch_arbiter_pkg;

   localparam int DISPATCH_DATA_WIDTH  = 32;
   localparam int DISPATCH_INDEX_WIDTH = 8;
   localparam int DISPATCH_NUM_REQ     = 4;
   localparam int DISPATCH_NUM_REQ_MIN = 2;
   localparam int DISPATCH_NUM_REQ_MAX = 8;
   localparam int DISPATCH_CNT_WIDTH   = 32;

   // Priority restarts one past the requester that was just served.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/dispatch_arbiter_if.sv
// Requester-side and dispatch-RAM-side signals of the dispatch arbiter.
// slave = arbiter, master = requesters plus the RAM model behind them.
interface dispatch_arbiter_if
   import dispatch_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = DISPATCH_NUM_REQ,
   parameter int DATA_WIDTH  = DISPATCH_DATA_WIDTH,
   parameter int INDEX_WIDTH = DISPATCH_INDEX_WIDTH
) ();

   logic [NUM_REQ-1:0]             rd_req;
   logic [NUM_REQ*INDEX_WIDTH-1:0] rd_addr;
   logic [NUM_REQ-1:0]             wr_req;
   logic [NUM_REQ*INDEX_WIDTH-1:0] wr_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data;
   logic [NUM_REQ-1:0]             rd_grant;
   logic [NUM_REQ-1:0]             wr_grant;
   logic [NUM_REQ-1:0]             rd_valid;
   logic [DATA_WIDTH-1:0]          rd_data;
   logic                           ram_read;
   logic [INDEX_WIDTH-1:0]         ram_out_address;
   logic                           ram_write;
   logic [INDEX_WIDTH-1:0]         ram_in_address;
   logic [DATA_WIDTH-1:0]          ram_in_data;
   logic [DATA_WIDTH-1:0]          ram_out_data;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_out_data,
      output rd_grant, wr_grant, rd_valid, rd_data,
             ram_read, ram_out_address, ram_write, ram_in_address, ram_in_data
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_out_data,
      input  rd_grant, wr_grant, rd_valid, rd_data,
             ram_read, ram_out_address, ram_write, ram_in_address, ram_in_data
   );

endinterface

// File: rtl/dispatch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr_i.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
   import dispatch_arbiter_pkg::*;
#(
   parameter  int N  = DISPATCH_NUM_REQ,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  mask_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   logic [N-1:0]  eff;
   logic [PW-1:0] slot;

   assign eff = req_i & ~mask_i;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      slot  = '0;
      for (int k = 0; k < N; k++) begin
         slot = PW'((int'(ptr_i) + k) % N);
         if (!any_o && eff[slot]) begin
            gnt_o[slot] = 1'b1;
            idx_o       = slot;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dispatch_arbiter.sv
// Independent round-robin read/write arbitration onto one dispatch RAM; grants and
// RAM commands one cycle after sampling, read data one cycle after that.
module dispatch_arbiter
   import dispatch_arbiter_pkg::*;
#(
   parameter int CORE        = 0,
   parameter int DATA_WIDTH  = DISPATCH_DATA_WIDTH,
   parameter int INDEX_WIDTH = DISPATCH_INDEX_WIDTH,
   parameter int NUM_REQ     = DISPATCH_NUM_REQ
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               report,
   dispatch_arbiter_if.slave  bus
);

   localparam int PW = $clog2(NUM_REQ);

   if (NUM_REQ < DISPATCH_NUM_REQ_MIN || NUM_REQ > DISPATCH_NUM_REQ_MAX) begin : g_bad_num_req
      $error("dispatch_arbiter: NUM_REQ out of range");
   end

   logic [NUM_REQ-1:0]            rd_win, wr_win;
   logic [PW-1:0]                 rd_idx, wr_idx;
   logic                          rd_any, wr_any;
   logic [INDEX_WIDTH-1:0]        rd_addr_sel, wr_addr_sel;
   logic [DATA_WIDTH-1:0]         wr_data_sel;
   logic                          conflict, rd_issue;

   logic [PW-1:0]                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [NUM_REQ-1:0]            rd_grant_q, rd_grant_d, wr_grant_q, wr_grant_d;
   logic [NUM_REQ-1:0]            rd_valid_q, rd_valid_d;
   logic [INDEX_WIDTH-1:0]        ram_out_address_q, ram_out_address_d;
   logic [INDEX_WIDTH-1:0]        ram_in_address_q, ram_in_address_d;
   logic [DATA_WIDTH-1:0]         ram_in_data_q, ram_in_data_d;
   logic [DATA_WIDTH-1:0]         rd_data_q, rd_data_d;
   logic [DISPATCH_CNT_WIDTH-1:0] cycles_q, cycles_d;
   logic [DISPATCH_CNT_WIDTH-1:0] rd_grants_q, rd_grants_d, wr_grants_q, wr_grants_d;

   // Masking with the grant currently on the wires keeps a requester that is
   // still dropping its request from being issued twice.
   rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .req_i (bus.rd_req),
      .mask_i(rd_grant_q),
      .ptr_i (rd_ptr_q),
      .gnt_o (rd_win),
      .idx_o (rd_idx),
      .any_o (rd_any)
   );

   rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .req_i (bus.wr_req),
      .mask_i(wr_grant_q),
      .ptr_i (wr_ptr_q),
      .gnt_o (wr_win),
      .idx_o (wr_idx),
      .any_o (wr_any)
   );

   assign rd_addr_sel = bus.rd_addr[int'(rd_idx)*INDEX_WIDTH +: INDEX_WIDTH];
   assign wr_addr_sel = bus.wr_addr[int'(wr_idx)*INDEX_WIDTH +: INDEX_WIDTH];
   assign wr_data_sel = bus.wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      // A same-address pair lets the write land first; the read retries next edge.
      conflict          = rd_any && wr_any && (rd_addr_sel == wr_addr_sel);
      rd_issue          = rd_any && !conflict;
      rd_grant_d        = rd_issue ? rd_win : '0;
      wr_grant_d        = wr_win;
      rd_ptr_d          = rd_issue ? PW'(rr_next(int'(rd_idx), NUM_REQ)) : rd_ptr_q;
      wr_ptr_d          = wr_any   ? PW'(rr_next(int'(wr_idx), NUM_REQ)) : wr_ptr_q;
      rd_valid_d        = rd_grant_q;
      ram_out_address_d = rd_issue ? rd_addr_sel : ram_out_address_q;
      ram_in_address_d  = wr_any   ? wr_addr_sel : ram_in_address_q;
      ram_in_data_d     = wr_any   ? wr_data_sel : ram_in_data_q;
      rd_data_d         = (|rd_grant_q) ? bus.ram_out_data : rd_data_q;
      cycles_d          = cycles_q + 1'b1;
      rd_grants_d       = rd_grants_q + DISPATCH_CNT_WIDTH'(rd_issue);
      wr_grants_d       = wr_grants_q + DISPATCH_CNT_WIDTH'(wr_any);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q          <= '0;
         wr_ptr_q          <= '0;
         rd_grant_q        <= '0;
         wr_grant_q        <= '0;
         rd_valid_q        <= '0;
         ram_out_address_q <= '0;
         ram_in_address_q  <= '0;
         ram_in_data_q     <= '0;
         rd_data_q         <= '0;
         cycles_q          <= '0;
         rd_grants_q       <= '0;
         wr_grants_q       <= '0;
      end else begin
         rd_ptr_q          <= rd_ptr_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_grant_q        <= rd_grant_d;
         wr_grant_q        <= wr_grant_d;
         rd_valid_q        <= rd_valid_d;
         ram_out_address_q <= ram_out_address_d;
         ram_in_address_q  <= ram_in_address_d;
         ram_in_data_q     <= ram_in_data_d;
         rd_data_q         <= rd_data_d;
         cycles_q          <= cycles_d;
         rd_grants_q       <= rd_grants_d;
         wr_grants_q       <= wr_grants_d;
      end
   end

   assign bus.rd_grant        = rd_grant_q;
   assign bus.wr_grant        = wr_grant_q;
   assign bus.rd_valid        = rd_valid_q;
   assign bus.rd_data         = rd_data_q;
   assign bus.ram_read        = |rd_grant_q;
   assign bus.ram_write       = |wr_grant_q;
   assign bus.ram_out_address = ram_out_address_q;
   assign bus.ram_in_address  = ram_in_address_q;
   assign bus.ram_in_data     = ram_in_data_q;

   // Simulation-only status print; synthesis drops system tasks.
   always_ff @(posedge clock) begin
      if (reset && report) begin
         $display("[core %0d] cycles=%0d rd_ptr=%0d wr_ptr=%0d rd_req=%b wr_req=%b rd_grant=%b wr_grant=%b rd_grants=%0d wr_grants=%0d",
                  CORE, cycles_q, rd_ptr_q, wr_ptr_q, bus.rd_req, bus.wr_req,
                  rd_grant_q, wr_grant_q, rd_grants_q, wr_grants_q);
      end
   end

endmodule
